// File: rtl/axi_read_vector_multi_if.sv
// axi_read_vector_multi_if: AXI-Stream bundle (tdata/tvalid/tlast/tready) with master and slave modports
interface axi_read_vector_multi_if #(
  parameter int DW = 32
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axi_read_vector_multi.sv
// axi_read_vector_multi: AXI-Stream deframer capturing one run-time-length bit vector into a register
// Ports: clk, rst_n (async active-low), start, vec_length, data_in (stream slave),
//        busy, done, err_len, err_short, err_long, vec, and popcount when
//        AXI_READ_VECTOR_MULTI_POPCOUNT_EN is defined.
module axi_read_vector_multi #(
  parameter int MAX_VEC_LENGTH = 256,
  parameter int AXI_DATA_WIDTH = 32,
  parameter bit MSB_FIRST      = 1'b0,
  parameter int LEN_W          = $clog2(MAX_VEC_LENGTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          vec_length,
  axi_read_vector_multi_if.slave    data_in,
  output logic                      busy,
  output logic                      done,
  output logic                      err_len,
  output logic                      err_short,
  output logic                      err_long,
  output logic [MAX_VEC_LENGTH-1:0] vec
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
  ,output logic [LEN_W-1:0]         popcount
`endif
);
  localparam int W   = AXI_DATA_WIDTH;
  localparam int NCH = (MAX_VEC_LENGTH + W - 1) / W;
  localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;
  localparam int NW  = CW + 1;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [NW-1:0]             n_q, n_d, idx;
  logic [CW-1:0]             k_q, k_d;
  logic [MAX_VEC_LENGTH-1:0] vec_q, vec_d;
  logic                      el_q, el_d, es_q, es_d, eg_q, eg_d;
  logic                      beat, last_k, len_ok;
  logic [W-1:0]              chunk;
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
  logic [LEN_W-1:0]          pc_q, pc_d;
  assign popcount = pc_q;
`endif
  assign busy         = state_q == READ || state_q == DRAIN;
  assign done         = state_q == DONE;
  assign data_in.tready = busy;
  assign beat         = data_in.tvalid && busy;
  assign len_ok       = vec_length != '0 && int'(vec_length) <= MAX_VEC_LENGTH;
  assign idx          = MSB_FIRST ? n_q - NW'(1) - {1'b0, k_q} : {1'b0, k_q};
  assign last_k       = {1'b0, k_q} == n_q - NW'(1);
  assign {vec, err_len, err_short, err_long} = {vec_q, el_q, es_q, eg_q};
  // Bits of the current chunk at or beyond the latched length are forced to zero.
  always_comb begin
    chunk = '0;
    for (int j = 0; j < W; j++) chunk[j] = data_in.tdata[j] & (int'(idx) * W + j < int'(len_q));
  end
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    n_d     = n_q;
    k_d     = k_q;
    vec_d   = vec_q;
    el_d    = el_q;
    es_d    = es_q;
    eg_d    = eg_q;
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
    pc_d    = pc_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        len_d   = vec_length;
        n_d     = NW'((int'(vec_length) + W - 1) / W);
        k_d     = '0;
        vec_d   = '0;
        el_d    = !len_ok;
        es_d    = 1'b0;
        eg_d    = 1'b0;
        state_d = len_ok ? READ : DONE;
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
        pc_d    = '0;
`endif
      end
      READ: if (beat) begin
        // Loop bound stops a chunk that overhangs the register from writing past its top.
        for (int i = 0; i < MAX_VEC_LENGTH; i++) if (i / W == int'(idx)) vec_d[i] = chunk[i % W];
        k_d = k_q + CW'(1);
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
        pc_d = pc_q + LEN_W'($countones(chunk));
`endif
        if (last_k) begin
          eg_d    = !data_in.tlast;
          state_d = data_in.tlast ? DONE : DRAIN;
        end else if (data_in.tlast) begin
          es_d    = 1'b1;
          state_d = DONE;
        end
      end
      DRAIN: state_d = beat && data_in.tlast ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      vec_q   <= '0;
      el_q    <= 1'b0;
      es_q    <= 1'b0;
      eg_q    <= 1'b0;
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
      pc_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      n_q     <= n_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
      el_q    <= el_d;
      es_q    <= es_d;
      eg_q    <= eg_d;
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
      pc_q    <= pc_d;
`endif
    end
  end
endmodule

// File: tb/tb_axi_read_vector_multi.sv
// tb_axi_read_vector_multi: randomized frames checked against a beat-level reference model, LSB- and MSB-first DUTs side by side
module tb_axi_read_vector_multi;
  localparam int MAXL = 256;
  localparam int W    = 32;
  localparam int LW   = 9;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic          start = 1'b0;
  logic [LW-1:0] vlen = '0;
  logic          tv = 1'b0, tl = 1'b0;
  logic [W-1:0]  td = '0;
  axi_read_vector_multi_if #(.DW(W)) s0 ();
  axi_read_vector_multi_if #(.DW(W)) s1 ();
  assign s0.tdata = td;
  assign s0.tvalid = tv;
  assign s0.tlast = tl;
  assign s1.tdata = td;
  assign s1.tvalid = tv;
  assign s1.tlast = tl;
  logic            busy0, done0, el0, es0, eg0, busy1, done1, el1, es1, eg1;
  logic [MAXL-1:0] vec0, vec1;
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
  logic [LW-1:0]   pc0, pc1;
`endif
  axi_read_vector_multi #(.MAX_VEC_LENGTH(MAXL), .AXI_DATA_WIDTH(W), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_length(vlen), .data_in(s0),
    .busy(busy0), .done(done0), .err_len(el0), .err_short(es0), .err_long(eg0), .vec(vec0)
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
    , .popcount(pc0)
`endif
  );
  axi_read_vector_multi #(.MAX_VEC_LENGTH(MAXL), .AXI_DATA_WIDTH(W), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_length(vlen), .data_in(s1),
    .busy(busy1), .done(done1), .err_len(el1), .err_short(es1), .err_long(eg1), .vec(vec1)
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
    , .popcount(pc1)
`endif
  );
  int tests = 0;
  int fails = 0;
  logic            eb = 1'b0, ed = 1'b0, ev_ok = 1'b1;
  logic [MAXL-1:0] xv0 = '0, xv1 = '0, nx0, nx1;
  logic            xel = 1'b0, xes = 1'b0, xeg = 1'b0, nel, nes, neg;
  logic [W-1:0]    bd[$];
  bit              bl[$];
  task automatic chk(input string nm, input logic [MAXL-1:0] a, input logic [MAXL-1:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask
  always @(negedge clk) if (rst_n) begin
    chk("busy0", busy0, eb);
    chk("busy1", busy1, eb);
    chk("tready0", s0.tready, eb);
    chk("tready1", s1.tready, eb);
    chk("done0", done0, ed);
    chk("done1", done1, ed);
    if (ev_ok) begin
      chk("vec0", vec0, xv0);
      chk("vec1", vec1, xv1);
      chk("errs0", {el0, es0, eg0}, {xel, xes, xeg});
      chk("errs1", {el1, es1, eg1}, {xel, xes, xeg});
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
      chk("pop0", pc0, $countones(xv0));
      chk("pop1", pc1, $countones(xv1));
`endif
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 1'b0; vlen = LW'($urandom); tv = 1'($urandom); td = $urandom; tl = 1'($urandom);
      eb = 1'b0; ed = 1'b0;
    end
  endtask
  // vmode 0: tvalid always high, 1: 1010 pattern, 2: random
  task automatic run_frame(input int len, input int vmode);
    int n, cons, k, cyc, p0, p1;
    bit fin, v;
    nx0 = '0; nx1 = '0; nel = 1'b0; nes = 1'b0; neg = 1'b0; cons = -1;
    n = (len + W - 1) / W;
    if (len < 1 || len > MAXL) nel = 1'b1;
    else for (int b = 0; b < bd.size(); b++) begin
      if (b < n) for (int j = 0; j < W; j++) begin
        p0 = b * W + j;
        p1 = (n - 1 - b) * W + j;
        if (p0 < len) nx0[p0] = bd[b][j];
        if (p1 < len) nx1[p1] = bd[b][j];
      end
      if (b < n - 1 && bl[b]) begin nes = 1'b1; cons = b; break; end
      if (b == n - 1 && !bl[b]) neg = 1'b1;
      else if (b >= n - 1 && bl[b]) begin cons = b; break; end
    end
    @(posedge clk); #1;
    start = 1'b1; vlen = LW'(len); tv = 1'($urandom); td = $urandom; tl = 1'($urandom);
    eb = 1'b0; ed = 1'b0;
    if (!nel) begin
      if (cons < 0) begin
        $display("FAIL frame_setup: got no tlast want one in %0d beats", bd.size());
        $fatal(1);
      end
      k = 0; cyc = 0; fin = 1'b0;
      while (!fin) begin
        @(posedge clk); #1;
        start = $urandom_range(0, 7) == 0; vlen = LW'($urandom);
        v = vmode == 0 ? 1'b1 : vmode == 1 ? cyc % 2 == 0 : 1'($urandom);
        cyc++;
        tv = v; td = v ? bd[k] : $urandom; tl = v ? bl[k] : 1'($urandom);
        eb = 1'b1; ed = 1'b0; ev_ok = 1'b0;
        if (v) begin
          fin = k == cons;
          k++;
        end
      end
    end
    @(posedge clk); #1;
    start = 1'($urandom); vlen = LW'($urandom); tv = 1'($urandom); td = $urandom; tl = 1'($urandom);
    eb = 1'b0; ed = 1'b1; ev_ok = 1'b1;
    xv0 = nx0; xv1 = nx1; xel = nel; xes = nes; xeg = neg;
  endtask
  task automatic set_beats(input logic [W-1:0] d0, d1, d2, d3, input int nb, input int lastb);
    logic [W-1:0] d[4];
    d = '{d0, d1, d2, d3};
    bd.delete(); bl.delete();
    for (int i = 0; i < nb; i++) begin
      bd.push_back(d[i]);
      bl.push_back(i == lastb);
    end
  endtask
  initial begin
    int len, n, m, s, nb;
    #2;
    chk("rst_vec0", vec0, '0);
    chk("rst_vec1", vec1, '0);
    chk("rst_flags", {busy0, done0, el0, es0, eg0, s0.tready}, '0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
    set_beats(32'hDEADBEEF, 32'hFFFFFFFF, 0, 0, 2, 1);
    run_frame(40, 0);
    chk("t1_vec0", vec0, 256'hFF_DEADBEEF);
    chk("t1_vec1", vec1, 256'hEF_FFFFFFFF);
    chk("t1_done", {done0, el0, es0, eg0}, 4'b1000);
`ifdef AXI_READ_VECTOR_MULTI_POPCOUNT_EN
    chk("t1_pop", pc0, 32);
`endif
    set_beats(32'h11111111, 32'h22222222, 0, 0, 2, 1);
    run_frame(64, 0);
    chk("t2_vec1", vec1, 256'h11111111_22222222);
    chk("t2_vec0", vec0, 256'h22222222_11111111);
    set_beats(32'hAAAAAAAA, 32'h55555555, 32'h12345678, 0, 3, 1);
    run_frame(96, 0);
    chk("t3_vec0", vec0, 256'h55555555_AAAAAAAA);
    chk("t3_err", {done0, es0, s0.tready}, 3'b110);
    set_beats(32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 0, 3, 2);
    run_frame(32, 0);
    chk("t4_vec0", vec0, 256'hCAFEF00D);
    chk("t4_err", {done0, eg0, es0}, 3'b110);
    bd.delete(); bl.delete();
    run_frame(0, 0);
    chk("t5_len0", {done0, el0, vec0 == '0}, 3'b111);
    run_frame(257, 0);
    chk("t5_len257", {done0, el0, busy0}, 3'b110);
    idle(1);
    set_beats(32'h0F0F0F0F, 32'hF0F0F0F0, 32'h33333333, 32'hCCCCCCCC, 4, 3);
    run_frame(128, 1);
    chk("t6_vec0", vec0, 256'hCCCCCCCC_33333333_F0F0F0F0_0F0F0F0F);
    @(posedge clk); #1;
    start = 1'b1; vlen = 9'd128; tv = 1'b0; eb = 1'b0; ed = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      start = 1'b0; tv = 1'b1; td = $urandom | 32'h1; tl = 1'b0; eb = 1'b1; ev_ok = 1'b0;
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("amid_vec", {vec0, vec1} == '0, 1'b1);
    chk("amid_flags", {busy0, done0, el0, es0, eg0, s0.tready, busy1, s1.tready}, '0);
    tv = 1'b0; eb = 1'b0; ed = 1'b0; ev_ok = 1'b1;
    xv0 = '0; xv1 = '0; xel = 1'b0; xes = 1'b0; xeg = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);
    repeat (300) begin
      case ($urandom_range(0, 9))
        0: len = 0;
        1: len = 257 + $urandom_range(0, 254);
        2: len = MAXL;
        3: len = 1;
        4: len = W * $urandom_range(1, MAXL / W);
        default: len = $urandom_range(1, MAXL);
      endcase
      bd.delete(); bl.delete();
      if (len >= 1 && len <= MAXL) begin
        n = (len + W - 1) / W;
        m = $urandom_range(0, 2);
        if (m == 1 && n < 2) m = 0;
        s = m == 1 ? $urandom_range(0, n - 2) : n - 1;
        nb = m == 2 ? n + $urandom_range(1, 3) : n;
        for (int i = 0; i < nb; i++) begin
          bd.push_back($urandom);
          bl.push_back(m == 2 ? i == nb - 1 : i == s);
        end
      end
      run_frame(len, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end
endmodule

// File: doc/axi_read_vector_multi.md
Name: axi_read_vector_multi

Overview:
- Stream-to-register deframer. Captures one variable-length bit vector from an AXI-Stream slave into a parallel register.
- Vector length is given at run time. Beat order is selectable. tlast framing is checked, and oversize frames are drained.
- Feeds puzzle-solver datapaths that need a whole vector (lights, masks) before compute starts.
- Successor to the single-chunk reader: adds a proper handshake, length validation, framing errors, clear-on-start and an MSB-first mode.

Parameters:
- MAX_VEC_LENGTH, 256, maximum vector length in bits (≥1).
- AXI_DATA_WIDTH, 32, tdata width in bits (≥1).
- MSB_FIRST, 0, beat order. 0: beat k fills chunk k. 1: beat k fills chunk N-1-k.
- LEN_W, $clog2(MAX_VEC_LENGTH+1), width of vec_length (derived; do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a capture; sampled only in IDLE.
- vec_length  in  LEN_W  requested length in bits; latched on accepted start.
- data_in  axi_stream_if slave  AXI_DATA_WIDTH  uses tdata, tvalid, tlast; drives tready.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when a capture ends, good or bad.
- err_len  out  1  latched; vec_length == 0 or vec_length > MAX_VEC_LENGTH.
- err_short  out  1  latched; tlast arrived before the final beat.
- err_long  out  1  latched; final beat arrived without tlast, frame drained.
- vec  out  MAX_VEC_LENGTH  captured vector; bits ≥ latched length are 0.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, err_* and vec all 0; tready 0.
- Definitions:
  - N = ceil(len/AXI_DATA_WIDTH), computed once at start from the latched length.
  - beat = tvalid && tready.
  - Chunk counter is $clog2(ceil(MAX_VEC_LENGTH/AXI_DATA_WIDTH)) bits wide, minimum 1.
- IDLE:
  - tready = 0.
  - On start: latch length, clear vec and all err_*.
  - If length invalid: set err_len and go to DONE (no beats consumed).
  - Otherwise go to READ with the counter at 0.
- READ:
  - tready = 1.
  - Each beat writes tdata into chunk index k (or N-1-k when MSB_FIRST) and increments k.
  - The last chunk is masked: bits at or above the latched length are written as 0.
  - A final chunk that overhangs MAX_VEC_LENGTH is truncated, with no out-of-range writes.
  - Beat with tlast and k < N-1: set err_short, go to DONE. Partial vec is retained.
  - Beat with k == N-1 and tlast: go to DONE.
  - Beat with k == N-1 and no tlast: set err_long, go to DRAIN.
  - tvalid low: hold all state; no timeout.
- DRAIN:
  - tready = 1.
  - Beats are discarded; vec is unchanged.
  - Beat with tlast: go to DONE.
- DONE:
  - done = 1 for exactly one cycle, busy = 0, tready = 0.
  - Next state is IDLE.
  - vec and err_* hold until the next accepted start.
- busy is high in READ and DRAIN. The capture takes N beat cycles plus one DONE cycle.
- start outside IDLE is ignored. vec_length is only sampled when start is accepted.
- start in the cycle after DONE is accepted normally, giving back-to-back frames with one IDLE cycle between them.
- Reset mid-frame aborts to IDLE. Any remaining stream beats belong to the upstream and are not drained.

Optional Feature:
- Macro: AXI_READ_VECTOR_MULTI_POPCOUNT_EN.
- With the macro defined:
  - Adds output popcount, width LEN_W.
  - Accumulated incrementally with each accepted masked chunk; cleared on start and reset.
  - Valid and stable from the done cycle until the next start.
  - DRAIN beats are not counted. err_short leaves the partial count.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- W=32, len=40, MSB_FIRST=0. Beats 0xDEADBEEF, then 0xFFFFFFFF with tlast -> vec[31:0]=0xDEADBEEF, vec[39:32]=0xFF, vec[255:40]=0. done pulses one cycle after the 2nd beat; no errors; popcount=32.
- len=64, MSB_FIRST=1. Beats 0x11111111, then 0x22222222 with tlast -> vec[63:32]=0x11111111, vec[31:0]=0x22222222.
- len=96, tlast on beat 2 of 3 -> err_short=1, done pulses, vec[95:64]=0, tready low next cycle.
- len=32, 3 beats with tlast on beat 3 -> err_long=1 after beat 1. Beats 2 and 3 are consumed but vec holds beat 1; done fires after beat 3.
- Invalid length and ignored start:
  - len=0 -> err_len, done after 2 cycles, no tready.
  - len=257 -> same.
  - start pulsed mid-READ -> ignored.
- tvalid toggled 1010 over a 4-beat frame -> correct vec. Then rst_n asserted mid-frame -> all outputs 0 immediately (async), state IDLE.
